// File: rtl/vga_pkg.sv
// Shared VGA timing constants and colour types for vga_timing and renderer.
// Defaults describe 640x480@60 Hz from a 50 MHz clock.
package vga_pkg;

    localparam int unsigned COLOR_W = 2;
    localparam int unsigned COORD_W = 10;

    localparam int unsigned DEF_CLK_DIV  = 2;
    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    localparam int unsigned DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int unsigned DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    typedef logic [COLOR_W-1:0] color_t;

    typedef struct packed {
        color_t r;
        color_t g;
        color_t b;
    } rgb_t;

    // True when lo <= val < lo+len.
    function automatic logic in_window(logic [COORD_W-1:0] val, int unsigned lo,
                                       int unsigned len);
        return (32'(val) >= lo) && (32'(val) < lo + len);
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with synchronous active-low reset to RESET_VAL.
module vga_delay_line #(
    parameter int unsigned          WIDTH     = 1,
    parameter int unsigned          DEPTH     = 2,
    parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage[i] <= RESET_VAL;
            end
        end else begin
            stage[0] <= din;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/vga_timing.sv
// VGA timing generator: pixel strobe/coordinates to renderer, colour capture,
// and sync/colour pins aligned two clocks behind the strobe.
module vga_timing
    import vga_pkg::*;
#(
    parameter int unsigned CLK_DIV  = DEF_CLK_DIV,
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       pixel_read,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    input  logic [1:0] R,
    input  logic [1:0] G,
    input  logic [1:0] B,
    output logic       frame_start,
    output logic [1:0] VGA_R,
    output logic [1:0] VGA_G,
    output logic [1:0] VGA_B,
    output logic       VGA_HS,
    output logic       VGA_VS
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] H_VIS    = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] V_VIS    = COORD_W'(V_ACTIVE);

    logic [DIV_W-1:0]   div;
    logic [COORD_W-1:0] h;
    logic [COORD_W-1:0] v;
    logic               tick;
    logic               active;
    logic               hs_raw;
    logic               vs_raw;
    logic               tick_d;
    logic               active_d;
    logic               cap;
    rgb_t               pix_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div <= '0;
            h   <= '0;
            v   <= '0;
        end else if (tick) begin
            div <= '0;
            if (h == H_LAST) begin
                h <= '0;
                v <= (v == V_LAST) ? '0 : v + 1'b1;
            end else begin
                h <= h + 1'b1;
            end
        end else begin
            div <= div + 1'b1;
        end
    end

    always_comb begin
        tick   = (div == DIV_LAST);
        active = (h < H_VIS) && (v < V_VIS);
        hs_raw = !in_window(h, H_ACTIVE + H_FP, H_SYNC);
        vs_raw = !in_window(v, V_ACTIVE + V_FP, V_SYNC);
    end

    assign pixel_read  = tick && active;
    assign frame_start = tick && (h == '0) && (v == '0);
    assign pixel_x     = h;
    assign pixel_y     = v;

    // One-stage copy of {tick, active}: cap is pixel_read delayed by one clock,
    // and a delayed tick with inactive position blanks the pins.
    vga_delay_line #(
        .WIDTH    (2),
        .DEPTH    (1),
        .RESET_VAL(2'b00)
    ) u_strobe_dly (
        .clk  (clk),
        .rst_n(rst_n),
        .din  ({tick, active}),
        .dout ({tick_d, active_d})
    );

    assign cap = tick_d && active_d;

    vga_delay_line #(
        .WIDTH    (2),
        .DEPTH    (2),
        .RESET_VAL(2'b11)
    ) u_sync_dly (
        .clk  (clk),
        .rst_n(rst_n),
        .din  ({hs_raw, vs_raw}),
        .dout ({VGA_HS, VGA_VS})
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pix_q <= '0;
        end else if (cap) begin
            pix_q <= '{r: R, g: G, b: B};
        end else if (tick_d) begin
            pix_q <= '0;
        end
    end

    assign VGA_R = pix_q.r;
    assign VGA_G = pix_q.g;
    assign VGA_B = pix_q.b;

endmodule

// File: tb/tb_vga_timing.sv
// Scoreboard bench for vga_timing: two reduced-geometry instances (CLK_DIV 2 and 4)
// checked cycle by cycle against a bench-side raster model and a renderer stand-in.
module tb_vga_timing;

    localparam int HA = 16, HF = 2, HSW = 4, HB = 3;
    localparam int VA = 8,  VF = 1, VSW = 2, VB = 2;
    localparam int HT = HA + HF + HSW + HB;
    localparam int VT = VA + VF + VSW + VB;
    localparam int RUN_CYCLES = 4500;

    typedef struct {
        int         due;
        int         d;
        bit         sync;
        logic [1:0] r, g, b;
        logic       hs, vs;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pr [2];
    logic       fs [2];
    logic       hs [2];
    logic       vs [2];
    logic [9:0] px [2];
    logic [9:0] py [2];
    logic [1:0] rin [2];
    logic [1:0] gin [2];
    logic [1:0] bin [2];
    logic [1:0] vr [2];
    logic [1:0] vg [2];
    logic [1:0] vb [2];

    int   checks = 0;
    int   errors = 0;
    exp_t sbq[$];

    int   cyc, tot;
    int   mh [2];
    int   mv [2];
    bit   prev_pr [2];
    logic [9:0] prev_x [2];
    logic [9:0] prev_y [2];
    int   sc [2];
    int   lfs [2];
    bit   have_fs [2];
    int   nframes [2];
    bit   mid_done, mid_pending;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        vga_timing #(
            .CLK_DIV (2 * (g + 1)),
            .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
            .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB)
        ) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .pixel_read (pr[g]),
            .pixel_x    (px[g]),
            .pixel_y    (py[g]),
            .R          (rin[g]),
            .G          (gin[g]),
            .B          (bin[g]),
            .frame_start(fs[g]),
            .VGA_R      (vr[g]),
            .VGA_G      (vg[g]),
            .VGA_B      (vb[g]),
            .VGA_HS     (hs[g]),
            .VGA_VS     (vs[g])
        );
    end

    function automatic int div_of(int d);
        return (d == 0) ? 2 : 4;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d (cycle %0d)", tag, got, exp, tot);
        end
    endtask

    task automatic reset_checks();
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst_pr%0d", d), 32'(pr[d]), 0);
            check($sformatf("rst_fs%0d", d), 32'(fs[d]), 0);
            check($sformatf("rst_px%0d", d), 32'(px[d]), 0);
            check($sformatf("rst_py%0d", d), 32'(py[d]), 0);
            check($sformatf("rst_rgb%0d", d), {26'd0, vr[d], vg[d], vb[d]}, 0);
            check($sformatf("rst_hs%0d", d), 32'(hs[d]), 1);
            check($sformatf("rst_vs%0d", d), 32'(vs[d]), 1);
        end
    endtask

    task automatic restart();
        sbq.delete();
        cyc = 0;
        for (int d = 0; d < 2; d++) begin
            mh[d] = 0;
            mv[d] = 0;
            prev_pr[d] = 1'b0;
            sc[d] = 0;
            have_fs[d] = 1'b0;
        end
    endtask

    task automatic step();
        bit trigger;
        trigger = 1'b0;
        for (int d = 0; d < 2; d++) begin
            int dv;
            bit tk, act;
            exp_t e;
            dv  = div_of(d);
            tk  = (cyc % dv) == dv - 1;
            act = (mh[d] < HA) && (mv[d] < VA);

            // Renderer stand-in: answers the previous strobe, otherwise drives junk.
            if (prev_pr[d]) begin
                rin[d] = prev_x[d][1:0];
                gin[d] = prev_y[d][1:0];
                bin[d] = prev_x[d][1:0] ^ prev_y[d][1:0];
            end else begin
                rin[d] = 2'($urandom);
                gin[d] = 2'($urandom);
                bin[d] = 2'($urandom);
            end
            prev_pr[d] = pr[d];
            prev_x[d]  = px[d];
            prev_y[d]  = py[d];

            check($sformatf("px%0d", d), 32'(px[d]), 32'(mh[d]));
            check($sformatf("py%0d", d), 32'(py[d]), 32'(mv[d]));
            check($sformatf("pixel_read%0d", d), 32'(pr[d]), 32'(tk && act));
            check($sformatf("frame_start%0d", d), 32'(fs[d]), 32'(tk && mh[d] == 0 && mv[d] == 0));

            if (fs[d] === 1'b1) begin
                if (have_fs[d]) begin
                    check($sformatf("frame_clks%0d", d), 32'(tot - lfs[d]), 32'(dv * HT * VT));
                    check($sformatf("frame_strobes%0d", d), 32'(sc[d]), 32'(HA * VA));
                    nframes[d]++;
                end
                have_fs[d] = 1'b1;
                lfs[d] = tot;
                sc[d] = 0;
            end
            if (pr[d] === 1'b1) sc[d]++;

            e = '{due: cyc + 2, d: d, sync: 1'b1, r: 2'd0, g: 2'd0, b: 2'd0,
                  hs: !(mh[d] >= HA + HF && mh[d] < HA + HF + HSW),
                  vs: !(mv[d] >= VA + VF && mv[d] < VA + VF + VSW)};
            sbq.push_back(e);

            if (tk) begin
                for (int k = 2; k <= dv + 1; k++) begin
                    e.due  = cyc + k;
                    e.sync = 1'b0;
                    e.r = act ? 2'(mh[d] % 4) : 2'd0;
                    e.g = act ? 2'(mv[d] % 4) : 2'd0;
                    e.b = act ? 2'((mh[d] ^ mv[d]) % 4) : 2'd0;
                    sbq.push_back(e);
                end
            end

            if (d == 0 && !mid_done && mh[0] == 10 && mv[0] == 5) trigger = 1'b1;

            if (tk) begin
                if (mh[d] == HT - 1) begin
                    mh[d] = 0;
                    mv[d] = (mv[d] == VT - 1) ? 0 : mv[d] + 1;
                end else begin
                    mh[d]++;
                end
            end
        end

        for (int i = sbq.size() - 1; i >= 0; i--) begin
            if (sbq[i].due == cyc) begin
                int d;
                d = sbq[i].d;
                if (sbq[i].sync) begin
                    check($sformatf("hsync%0d", d), 32'(hs[d]), 32'(sbq[i].hs));
                    check($sformatf("vsync%0d", d), 32'(vs[d]), 32'(sbq[i].vs));
                end else begin
                    check($sformatf("vga_r%0d", d), 32'(vr[d]), 32'(sbq[i].r));
                    check($sformatf("vga_g%0d", d), 32'(vg[d]), 32'(sbq[i].g));
                    check($sformatf("vga_b%0d", d), 32'(vb[d]), 32'(sbq[i].b));
                end
                sbq.delete(i);
            end
        end

        if (trigger) begin
            rst_n = 1'b0;
            mid_done = 1'b1;
            mid_pending = 1'b1;
        end
        cyc++;
        tot++;
    endtask

    initial begin
        tot = 0;
        mid_done = 1'b0;
        mid_pending = 1'b0;
        for (int d = 0; d < 2; d++) begin
            rin[d] = '0;
            gin[d] = '0;
            bin[d] = '0;
            nframes[d] = 0;
        end
        restart();

        rst_n = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
            reset_checks();
        end
        rst_n = 1'b1;
        restart();
        step();

        repeat (RUN_CYCLES) begin
            @(posedge clk);
            #1;
            if (mid_pending) begin
                reset_checks();
                rst_n = 1'b1;
                mid_pending = 1'b0;
                restart();
            end
            step();
        end

        check("mid_reset_done", 32'(mid_done), 1);
        check("frames_div2", 32'(nframes[0] >= 3), 1);
        check("frames_div4", 32'(nframes[1] >= 2), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
